// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: request, multiplier and result channels of the shared-multiplier arbiter.
interface mult_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATAWIDTH = 4
);
  localparam int IDW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*DATAWIDTH-1:0] req_a;
  logic [NUM_REQ*DATAWIDTH-1:0] req_b;
  logic mul_valid;
  logic [DATAWIDTH-1:0] mul_a;
  logic [DATAWIDTH-1:0] mul_b;
  logic mul_o_valid;
  logic [2*DATAWIDTH-1:0] mul_z;
  logic res_valid;
  logic res_ready;
  logic [IDW-1:0] res_id;
  logic [2*DATAWIDTH-1:0] res_data;
  logic err_unexpected;
  logic [NUM_REQ*16-1:0] grant_count;
  modport slave (
    input req_valid, req_a, req_b, mul_o_valid, mul_z, res_ready,
    output req_ready, mul_valid, mul_a, mul_b, res_valid, res_id, res_data, err_unexpected, grant_count
  );
  modport master (
    output req_valid, req_a, req_b, mul_o_valid, mul_z, res_ready,
    input req_ready, mul_valid, mul_a, mul_b, res_valid, res_id, res_data, err_unexpected, grant_count
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one pipelined multiplier with tagged in-order results.
// Define MULT_SHARE_ARB_STATS_EN to build per-requester saturating grant counters.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATAWIDTH = 4,
  parameter int MULT_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  mult_share_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = IDW + 2 * DATAWIDTH;
  if (MULT_LATENCY < 1) begin : g_bad_latency
    $error("MULT_LATENCY must be >= 1");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  logic [IDW-1:0] rr_q, win;
  logic found, issue_ok, hs, tag_pop, res_pop, res_nonempty;
  logic [IDW-1:0] tag_mem_q [FIFO_DEPTH];
  logic [RW-1:0] res_mem_q [FIFO_DEPTH];
  logic [PW-1:0] tag_wr_q, tag_rd_q, res_wr_q, res_rd_q;
  logic [CW-1:0] tag_cnt_q, res_cnt_q;
  logic mul_valid_q, err_q;
  logic [DATAWIDTH-1:0] mul_a_q, mul_b_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // Credits count every op from grant until its result leaves the buffer, so the
  // multiplier (which cannot stall) always finds room on return.
  always_comb begin
    issue_ok = rst && (int'(tag_cnt_q) + int'(res_cnt_q) < FIFO_DEPTH);
    found = 1'b0;
    win = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && bus.req_valid[(int'(rr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        win = IDW'((int'(rr_q) + i) % NUM_REQ);
      end
    hs = issue_ok && found;
    tag_pop = bus.mul_o_valid && tag_cnt_q != '0;
    res_nonempty = res_cnt_q != '0;
    res_pop = res_nonempty && bus.res_ready;
  end
  assign bus.req_ready = hs ? (NUM_REQ'(1) << win) : '0;
  assign bus.mul_valid = mul_valid_q;
  assign bus.mul_a = mul_a_q;
  assign bus.mul_b = mul_b_q;
  assign bus.res_valid = res_nonempty;
  assign {bus.res_id, bus.res_data} = res_nonempty ? res_mem_q[res_rd_q] : '0;
  assign bus.err_unexpected = err_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rr_q <= '0;
      mul_valid_q <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      tag_cnt_q <= '0;
      res_wr_q <= '0;
      res_rd_q <= '0;
      res_cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      mul_valid_q <= hs;
      if (hs) begin
        rr_q <= win == IDW'(NUM_REQ - 1) ? '0 : win + 1'b1;
        mul_a_q <= bus.req_a[win*DATAWIDTH +: DATAWIDTH];
        mul_b_q <= bus.req_b[win*DATAWIDTH +: DATAWIDTH];
        tag_wr_q <= inc(tag_wr_q);
      end
      if (tag_pop) begin
        tag_rd_q <= inc(tag_rd_q);
        res_wr_q <= inc(res_wr_q);
      end
      if (res_pop) res_rd_q <= inc(res_rd_q);
      tag_cnt_q <= tag_cnt_q + CW'(hs) - CW'(tag_pop);
      res_cnt_q <= res_cnt_q + CW'(tag_pop) - CW'(res_pop);
      if (bus.mul_o_valid && !tag_pop) err_q <= 1'b1;
    end
  always_ff @(posedge clk) begin
    if (hs) tag_mem_q[tag_wr_q] <= win;
    if (tag_pop) res_mem_q[res_wr_q] <= {tag_mem_q[tag_rd_q], bus.mul_z};
  end
`ifdef MULT_SHARE_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] gc_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) gc_q <= '0;
    else
      for (int k = 0; k < NUM_REQ; k++)
        if (hs && int'(win) == k && gc_q[k*16 +: 16] != 16'hFFFF) gc_q[k*16 +: 16] <= gc_q[k*16 +: 16] + 16'd1;
  assign bus.grant_count = gc_q;
`else
  assign bus.grant_count = '0;
`endif
endmodule
